muldiv_seq: RTL

- Iterative RV32M multiply/divide sequencer, placed beside the main ALU in the execute stage.
- Sequences one radix-2 add/subtract-and-shift step per cycle over DATA_WIDTH cycles.
- Holds the pipeline stalled through busy and presents the registered result with a one-cycle done pulse.
- The single-cycle ALU keeps ADD/SUB/logic/shift/SLT/LUI; this block owns MUL*/DIV*/REM*.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/muldiv_step.sv | 50 +++++
 rtl/muldiv_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and opcode decode helpers for the iterative
// RV32M multiply/divide sequencer.
//   muldiv_op_t    : funct3 encodings for MUL*/DIV*/REM*
//   muldiv_state_t : sequencer FSM states
//   is_div / is_signed_a / is_signed_b / returns_high / returns_rem : op decode
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // MUL only keeps the low half, which is sign-agnostic, so it runs unsigned.
    function automatic logic is_signed_a(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic returns_high(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic returns_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration on unsigned magnitudes.
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//   hi, lo   : current accumulator halves (multiply: product hi/lo,
//              divide: partial remainder / dividend-quotient shift register)
//   m        : multiplicand (multiply) or divisor (divide) magnitude
//   hi_nxt, lo_nxt : accumulator after this iteration
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  div_mode,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] m,
    output logic [DATA_WIDTH-1:0] hi_nxt,
    output logic [DATA_WIDTH-1:0] lo_nxt
);
    localparam int W = DATA_WIDTH;

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W+1:0] trial;
    logic         unused_trial_bit;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // keeping the carry so it shifts into the top of hi.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(W+1){1'b0}});
        // Divide: bring the next dividend bit into the partial remainder.
        // The shifted value may need W+1 bits, so the trial subtract is
        // done one bit wider again to expose the borrow.
        shifted = {hi, lo[W-1]};
        trial   = {1'b0, shifted} - {2'b00, m};
        // A successful subtract always leaves a value below the divisor.
        unused_trial_bit = trial[W];

        if (div_mode) begin
            if (trial[W+1]) begin
                hi_nxt = shifted[W-1:0];  // restore
                lo_nxt = {lo[W-2:0], 1'b0};
            end else begin
                hi_nxt = trial[W-1:0];
                lo_nxt = {lo[W-2:0], 1'b1};
            end
        end else begin
            hi_nxt = sum[W:1];
            lo_nxt = {sum[0], lo[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer (MUL*/DIV*/REM*).
// One radix-2 step per cycle over DATA_WIDTH cycles on operand magnitudes,
// followed by a sign-fixup cycle and a one-cycle done pulse.
//   clk, rst (sync, active-high)
//   start  : request, accepted in IDLE or DONE (DONE allows back-to-back)
//   kill   : flush; aborts CALC/FIXUP and wins over start
//   op     : funct3 (muldiv_op_t)
//   opA/opB: rs1/rs2, sampled only when a request is accepted
//   busy   : high in CALC and FIXUP
//   done   : one-cycle pulse with result/dbz valid
//   result : registered result, held until the next completion
//   dbz    : divide-by-zero flag, held with result
// Optional build macro MULDIV_FASTPATH_EN: divide-by-zero, signed overflow
// and multiply by zero skip CALC (IDLE -> FIXUP -> DONE).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  dbz
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    muldiv_state_t    state;
    logic [CNT_W-1:0] cnt;

    // Operation context captured at acceptance
    muldiv_op_t op_q;
    logic       neg_q;
    logic       dbz_q;
    logic [W-1:0] m_q;
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;
    logic [W-1:0] hi_step;
    logic [W-1:0] lo_step;

    // Acceptance-time decode of the incoming request
    muldiv_op_t   op_in;
    logic         div_in;
    logic         sign_a;
    logic         sign_b;
    logic         div0_in;
    logic         neg_in;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic         accept;
    logic         fast;

    assign op_in = muldiv_op_t'(op);

    always_comb begin
        div_in  = is_div(op_in);
        sign_a  = is_signed_a(op_in) & opA[W-1];
        sign_b  = is_signed_b(op_in) & opB[W-1];
        mag_a   = sign_a ? -opA : opA;
        mag_b   = sign_b ? -opB : opB;
        div0_in = div_in && (opB == '0);
        // Remainder follows the dividend; product and quotient follow the XOR.
        if (div_in && returns_rem(op_in)) neg_in = sign_a;
        else                              neg_in = sign_a ^ sign_b;
    end

    assign accept = (state == IDLE || state == DONE) && start && !kill;

`ifdef MULDIV_FASTPATH_EN
    logic ovf_in;
    logic mulz_in;
    assign ovf_in  = div_in && is_signed_a(op_in) &&
                     (opA == {1'b1, {(W-1){1'b0}}}) && (opB == '1);
    assign mulz_in = !div_in && ((opA == '0) || (opB == '0));
    assign fast    = div0_in || ovf_in || mulz_in;
`else
    assign fast = 1'b0;
`endif

    muldiv_step #(.DATA_WIDTH(W)) u_step (
        .div_mode (is_div(op_q)),
        .hi       (hi_q),
        .lo       (lo_q),
        .m        (m_q),
        .hi_nxt   (hi_step),
        .lo_nxt   (lo_step)
    );

    // Datapath registers: loaded at acceptance, stepped in CALC
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            dbz_q <= div0_in;
            m_q   <= div_in ? mag_b : mag_a;
            hi_q  <= '0;
            lo_q  <= div_in ? mag_a : mag_b;
            // Preload what the full iteration would have produced; signed
            // overflow already has |opA| as its quotient magnitude.
            if (fast) begin
                if (div0_in) begin
                    hi_q <= mag_a;
                    lo_q <= '1;
                end else if (!div_in) begin
                    lo_q <= '0;
                end
            end
        end else if (state == CALC) begin
            hi_q <= hi_step;
            lo_q <= lo_step;
        end
    end

    // Sign correction and result selection
    logic [2*W-1:0] prod;
    logic [W-1:0]   divres;
    logic [W-1:0]   fix_val;

    always_comb begin
        prod   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        divres = returns_rem(op_q) ? hi_q : lo_q;
        if (neg_q) divres = -divres;
        if (is_div(op_q)) begin
            // Quotient of x/0 is all ones regardless of the dividend sign;
            // the remainder naturally comes back as opA.
            if (dbz_q && !returns_rem(op_q)) fix_val = '1;
            else                             fix_val = divres;
        end else begin
            fix_val = returns_high(op_q) ? prod[2*W-1:W] : prod[W-1:0];
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            dbz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        busy  <= 1'b1;
                        cnt   <= CNT_W'(W);
                        state <= fast ? FIXUP : CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (kill) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    busy <= 1'b0;
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        result <= fix_val;
                        dbz    <= dbz_q;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
